mem_loader: RTL

- Upstream stage of the NockPU core. Accepts a stream of noun words from a host link and writes them into memory_unit through the standard memory handshake.
- Once the image is loaded, it launches mem_traversal at the entry address and waits for traversal_finished.
- It is the hardware replacement for the bench-side $readmemh preload, and the sole owner of memory until launch.

---
 rtl/mem_loader_pkg.sv | 22 ++
 rtl/mem_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader.
//   - Default memory address/data widths (mirroring the memory_unit widths).
//   - Memory function code used by the loader (write).
//   - Loader FSM state encodings (3-bit).
package mem_loader_pkg;

   localparam int MEM_ADDR_WIDTH = 10;
   localparam int MEM_DATA_WIDTH = 64;

   localparam logic [1:0] MEM_FUNC_WRITE = 2'd1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_MEM = 3'd1,
      S_ACCEPT   = 3'd2,
      S_ISSUE    = 3'd3,
      S_WAIT_ACK = 3'd4,
      S_LAUNCH   = 3'd5,
      S_DONE     = 3'd6
   } loader_state_t;

endpackage

// File: rtl/mem_loader.sv
// Memory image loader: streams host words into memory through the memory
// request handshake, then launches traversal at the entry address and waits
// for it to finish. Owns memory (mem_own) from load acceptance until launch.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   load_start/base/count, entry_addr   load request, sampled in IDLE only
//   in_valid, in_data, in_ready   host word stream
//   mem_func, mem_execute, address, write_data, mem_ready   memory handshake
//   mem_own                       memory mux select (1 = loader)
//   traversal_execute, start_addr, traversal_finished   traversal launch
//   busy, done, error             status (error is sticky until next accepted load)
//
// state    | meaning
// IDLE     | waiting for load_start; range check on request
// WAIT_MEM | owning memory, waiting for memory ready (e.g. out of reset)
// ACCEPT   | in_ready high, waiting for a host word
// ISSUE    | mem_execute high until memory drops ready
// WAIT_ACK | waiting for memory ready to return; advance index
// LAUNCH   | traversal_execute held high until traversal_finished
// DONE     | one-cycle done pulse, back to IDLE
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int ADDR_W    = MEM_ADDR_WIDTH,
   parameter int DATA_W    = MEM_DATA_WIDTH,
   parameter int MAX_WORDS = (1 << ADDR_W) - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-1:0] load_count,
   input  logic [ADDR_W-1:0] entry_addr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [1:0]        mem_func,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic              mem_ready,
   output logic              mem_own,
   output logic              traversal_execute,
   output logic [ADDR_W-1:0] start_addr,
   input  logic              traversal_finished,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] MAX_LAST = (ADDR_W+1)'(MAX_WORDS);

   loader_state_t     state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] count_q;
   logic [ADDR_W-1:0] entry_q;
   logic [ADDR_W-1:0] idx;

   // Last address of the requested window, one bit wider so an overflow of
   // the address space is visible. count==0 is rejected separately.
   logic [ADDR_W:0]   last_addr;
   logic              load_bad;
   logic [ADDR_W-1:0] idx_inc;

   assign last_addr = {1'b0, load_base} + {1'b0, load_count} - (ADDR_W+1)'(1);
   assign load_bad  = (load_count == '0) || (last_addr > MAX_LAST);
   assign idx_inc   = idx + ADDR_W'(1);
   assign mem_func  = MEM_FUNC_WRITE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= S_IDLE;
         base_q            <= '0;
         count_q           <= '0;
         entry_q           <= '0;
         idx               <= '0;
         in_ready          <= 1'b0;
         mem_execute       <= 1'b0;
         address           <= '0;
         write_data        <= '0;
         mem_own           <= 1'b0;
         traversal_execute <= 1'b0;
         start_addr        <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (load_start) begin
                  base_q  <= load_base;
                  count_q <= load_count;
                  entry_q <= entry_addr;
                  idx     <= '0;
                  error   <= load_bad;
                  if (!load_bad) begin
                     state   <= S_WAIT_MEM;
                     busy    <= 1'b1;
                     mem_own <= 1'b1;
                  end
               end
            end
            S_WAIT_MEM: begin
               if (mem_ready) begin
                  state    <= S_ACCEPT;
                  in_ready <= 1'b1;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  write_data  <= in_data;
                  address     <= base_q + idx;
                  in_ready    <= 1'b0;
                  mem_execute <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Memory drops ready once it has taken the request.
               if (!mem_ready) begin
                  mem_execute <= 1'b0;
                  state       <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (mem_ready) begin
                  idx <= idx_inc;
                  if (idx_inc == count_q) begin
                     state             <= S_LAUNCH;
                     mem_own           <= 1'b0;
                     start_addr        <= entry_q;
                     traversal_execute <= 1'b1;
                  end else begin
                     state    <= S_ACCEPT;
                     in_ready <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               if (traversal_finished) begin
                  traversal_execute <= 1'b0;
                  done              <= 1'b1;
                  state             <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
